// File: rtl/regs_writeback.sv
// Register-file writeback initiator: merges ALU results and buffered load
// returns onto one write port and tracks registers with loads still in flight.
package params;
    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned SEL_W    = $clog2(NUM_REGS);
    localparam int unsigned DATA_W   = 32;

    typedef logic [SEL_W-1:0]  reg_sel_t;
    typedef logic [DATA_W-1:0] data_t;

    typedef struct packed {
        reg_sel_t sel;
        data_t    data;
    } wb_entry_t;
endpackage

module regs_writeback #(
    parameter int unsigned LD_DEPTH = 2,
    parameter int unsigned NUM_REGS = params::NUM_REGS
) (
    input  logic                          i_clk,
    input  logic                          i_rst,

    input  logic                          i_alu_valid,
    output logic                          o_alu_ready,
    input  params::reg_sel_t              i_alu_sel,
    input  params::data_t                 i_alu_data,

    input  logic                          i_ld_valid,
    output logic                          o_ld_ready,
    input  params::reg_sel_t              i_ld_sel,
    input  params::data_t                 i_ld_data,

    input  logic                          i_issue_en,
    input  params::reg_sel_t              i_issue_sel,

    input  params::reg_sel_t              i_chk_sel_1,
    input  params::reg_sel_t              i_chk_sel_2,
    output logic                          o_busy_1,
    output logic                          o_busy_2,

    output logic                          o_write_en,
    output params::reg_sel_t              o_sel_write,
    output params::data_t                 o_write_data,
    output logic [$clog2(LD_DEPTH):0]     o_ld_count
);

    localparam int unsigned PTR_W = $clog2(LD_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(LD_DEPTH);

    params::wb_entry_t  r_fifo [LD_DEPTH];
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               r_wr_is_ld;
    logic [NUM_REGS-1:0] r_pending;

    logic               w_full;
    logic               w_empty;
    logic               w_alu_acc;
    logic               w_ld_push;
    logic               w_pop;
    logic               w_sel_valid;
    params::wb_entry_t  w_sel_entry;
    params::wb_entry_t  w_ld_entry;
    logic [NUM_REGS-1:0] w_pending_nxt;

    // Handshake and arbitration, all from registered FIFO state
    always_comb begin
        w_full      = (r_count == FULL_CNT);
        w_empty     = (r_count == '0);
        w_alu_acc   = i_alu_valid && !w_full;
        w_ld_push   = i_ld_valid && !w_full;
        // A full FIFO takes priority so loads can always drain
        w_pop       = !w_empty && (w_full || !i_alu_valid);
        w_sel_valid = w_alu_acc || w_pop;
        w_ld_entry  = '{sel: i_ld_sel, data: i_ld_data};
        if (w_pop) begin
            w_sel_entry = r_fifo[r_rd_ptr];
        end else begin
            w_sel_entry = '{sel: i_alu_sel, data: i_alu_data};
        end
    end

    assign o_alu_ready = !w_full;
    assign o_ld_ready  = !w_full;
    assign o_ld_count  = r_count;

    // Load-return FIFO storage; contents are don't-care when not counted
    always_ff @(posedge i_clk) begin
        if (w_ld_push) begin
            r_fifo[r_wr_ptr] <= w_ld_entry;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_ld_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_ld_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Write port register; register 0 is consumed but never written
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_write_en   <= 1'b0;
            o_sel_write  <= '0;
            o_write_data <= '0;
            r_wr_is_ld   <= 1'b0;
        end else if (w_sel_valid) begin
            o_write_en   <= (w_sel_entry.sel != '0);
            o_sel_write  <= w_sel_entry.sel;
            o_write_data <= w_sel_entry.data;
            r_wr_is_ld   <= w_pop;
        end else begin
            o_write_en   <= 1'b0;
            r_wr_is_ld   <= 1'b0;
        end
    end

    // Pending-load scoreboard: clear on load commit, new issue wins a collision
    always_comb begin
        w_pending_nxt = r_pending;
        if (o_write_en && r_wr_is_ld) begin
            w_pending_nxt[o_sel_write] = 1'b0;
        end
        if (i_issue_en && (i_issue_sel != '0)) begin
            w_pending_nxt[i_issue_sel] = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_nxt;
        end
    end

    assign o_busy_1 = (i_chk_sel_1 != '0) && r_pending[i_chk_sel_1];
    assign o_busy_2 = (i_chk_sel_2 != '0) && r_pending[i_chk_sel_2];

endmodule

// File: tb/tb_regs_writeback.sv
// Scoreboard bench for regs_writeback: directed stimulus queues expected
// register-file writes, a negedge monitor pops and compares every write.
module tb_regs_writeback;
    import params::*;

    localparam int unsigned LD_DEPTH = 2;

    logic       clk = 1'b0;
    logic       i_rst;
    logic       i_alu_valid, o_alu_ready;
    reg_sel_t   i_alu_sel;
    data_t      i_alu_data;
    logic       i_ld_valid, o_ld_ready;
    reg_sel_t   i_ld_sel;
    data_t      i_ld_data;
    logic       i_issue_en;
    reg_sel_t   i_issue_sel;
    reg_sel_t   i_chk_sel_1, i_chk_sel_2;
    logic       o_busy_1, o_busy_2;
    logic       o_write_en;
    reg_sel_t   o_sel_write;
    data_t      o_write_data;
    logic [$clog2(LD_DEPTH):0] o_ld_count;

    int checks = 0;
    int errors = 0;
    wb_entry_t exp_q[$];
    wb_entry_t mon_e;

    always #5 clk = ~clk;

    regs_writeback #(.LD_DEPTH(LD_DEPTH)) dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_alu_valid  (i_alu_valid),
        .o_alu_ready  (o_alu_ready),
        .i_alu_sel    (i_alu_sel),
        .i_alu_data   (i_alu_data),
        .i_ld_valid   (i_ld_valid),
        .o_ld_ready   (o_ld_ready),
        .i_ld_sel     (i_ld_sel),
        .i_ld_data    (i_ld_data),
        .i_issue_en   (i_issue_en),
        .i_issue_sel  (i_issue_sel),
        .i_chk_sel_1  (i_chk_sel_1),
        .i_chk_sel_2  (i_chk_sel_2),
        .o_busy_1     (o_busy_1),
        .o_busy_2     (o_busy_2),
        .o_write_en   (o_write_en),
        .o_sel_write  (o_sel_write),
        .o_write_data (o_write_data),
        .o_ld_count   (o_ld_count)
    );

    // Every register-file write must match the head of the expected queue
    always @(negedge clk) begin
        if (o_write_en === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL wb_unexpected: got sel=%0d data=%0h, required no write",
                         o_sel_write, o_write_data);
            end else begin
                mon_e = exp_q.pop_front();
                if (o_sel_write !== mon_e.sel || o_write_data !== mon_e.data) begin
                    errors++;
                    $display("FAIL wb_write: got sel=%0d data=%0h, required sel=%0d data=%0h",
                             o_sel_write, o_write_data, mon_e.sel, mon_e.data);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input reg_sel_t s, input data_t d);
        exp_q.push_back('{sel: s, data: d});
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int alu_k;
        int ld_k;
        int cyc;

        i_rst = 1'b1;
        i_alu_valid = 1'b0; i_alu_sel = '0; i_alu_data = '0;
        i_ld_valid  = 1'b0; i_ld_sel  = '0; i_ld_data  = '0;
        i_issue_en  = 1'b0; i_issue_sel = '0;
        i_chk_sel_1 = '0;   i_chk_sel_2 = '0;

        // Reset state
        next_cycle;
        next_cycle;
        i_chk_sel_1 = 5'd7; i_chk_sel_2 = 5'd9;
        @(negedge clk);
        chk("rst_write_en", 32'(o_write_en), 32'd0);
        chk("rst_sel_write", 32'(o_sel_write), 32'd0);
        chk("rst_write_data", o_write_data, 32'd0);
        chk("rst_ld_count", 32'(o_ld_count), 32'd0);
        chk("rst_ld_ready", 32'(o_ld_ready), 32'd1);
        chk("rst_alu_ready", 32'(o_alu_ready), 32'd1);
        chk("rst_busy_1", 32'(o_busy_1), 32'd0);
        next_cycle;
        i_rst = 1'b0;
        next_cycle;

        // ALU only
        i_alu_valid = 1'b1; i_alu_sel = 5'd5; i_alu_data = 32'h1234;
        push_exp(5'd5, 32'h1234);
        @(negedge clk);
        chk("alu_ready", 32'(o_alu_ready), 32'd1);
        next_cycle;
        i_alu_valid = 1'b0;
        @(negedge clk);
        chk("alu_write_en", 32'(o_write_en), 32'd1);
        next_cycle;
        @(negedge clk);
        chk("alu_idle_en", 32'(o_write_en), 32'd0);
        chk("alu_hold_sel", 32'(o_sel_write), 32'd5);
        chk("alu_hold_data", o_write_data, 32'h1234);

        // Load with scoreboard: issue cycle 1, return cycle 4, write cycle 6
        next_cycle;
        i_issue_en = 1'b1; i_issue_sel = 5'd7; i_chk_sel_1 = 5'd7;
        @(negedge clk);
        chk("ld_busy_c1", 32'(o_busy_1), 32'd0);
        next_cycle;
        i_issue_en = 1'b0;
        @(negedge clk);
        chk("ld_busy_c2", 32'(o_busy_1), 32'd1);
        next_cycle;
        @(negedge clk);
        chk("ld_busy_c3", 32'(o_busy_1), 32'd1);
        next_cycle;
        i_ld_valid = 1'b1; i_ld_sel = 5'd7; i_ld_data = 32'hCAFE;
        push_exp(5'd7, 32'hCAFE);
        @(negedge clk);
        chk("ld_ready_c4", 32'(o_ld_ready), 32'd1);
        next_cycle;
        i_ld_valid = 1'b0;
        @(negedge clk);
        chk("ld_count_c5", 32'(o_ld_count), 32'd1);
        chk("ld_en_c5", 32'(o_write_en), 32'd0);
        chk("ld_busy_c5", 32'(o_busy_1), 32'd1);
        next_cycle;
        @(negedge clk);
        chk("ld_en_c6", 32'(o_write_en), 32'd1);
        chk("ld_busy_c6", 32'(o_busy_1), 32'd1);
        chk("ld_count_c6", 32'(o_ld_count), 32'd0);
        next_cycle;
        @(negedge clk);
        chk("ld_busy_c7", 32'(o_busy_1), 32'd0);

        // Contention: ALU every cycle, two back-to-back loads
        next_cycle;
        push_exp(5'd1, 32'hA1);
        push_exp(5'd2, 32'hA2);
        push_exp(5'd10, 32'hB0);
        push_exp(5'd3, 32'hA3);
        push_exp(5'd4, 32'hA4);
        push_exp(5'd5, 32'hA5);
        push_exp(5'd6, 32'hA6);
        push_exp(5'd11, 32'hB1);
        alu_k = 1; ld_k = 0; cyc = 0;
        while (alu_k <= 6 && cyc < 30) begin
            i_alu_valid = 1'b1;
            i_alu_sel   = reg_sel_t'(alu_k);
            i_alu_data  = data_t'(32'hA0 + alu_k);
            i_ld_valid  = (ld_k < 2);
            i_ld_sel    = reg_sel_t'(10 + ld_k);
            i_ld_data   = data_t'(32'hB0 + ld_k);
            @(negedge clk);
            if (cyc == 2) begin
                chk("cont_count_full", 32'(o_ld_count), 32'd2);
                chk("cont_alu_stall", 32'(o_alu_ready), 32'd0);
                chk("cont_ld_stall", 32'(o_ld_ready), 32'd0);
            end
            if (cyc == 3) begin
                chk("cont_count_drain", 32'(o_ld_count), 32'd1);
            end
            if (o_alu_ready) alu_k++;
            if (i_ld_valid && o_ld_ready) ld_k++;
            next_cycle;
            cyc++;
        end
        i_alu_valid = 1'b0; i_ld_valid = 1'b0;
        chk("cont_cycles", 32'(cyc), 32'd7);
        chk("cont_loads_taken", 32'(ld_k), 32'd2);
        repeat (3) next_cycle;
        @(negedge clk);
        chk("cont_queue_drained", 32'(exp_q.size()), 32'd0);

        // x0 handling
        next_cycle;
        i_alu_valid = 1'b1; i_alu_sel = 5'd0; i_alu_data = 32'h55;
        @(negedge clk);
        chk("x0_alu_ready", 32'(o_alu_ready), 32'd1);
        next_cycle;
        i_alu_valid = 1'b0;
        i_ld_valid = 1'b1; i_ld_sel = 5'd0; i_ld_data = 32'h66;
        @(negedge clk);
        chk("x0_alu_en", 32'(o_write_en), 32'd0);
        chk("x0_alu_data", o_write_data, 32'h55);
        next_cycle;
        i_ld_valid = 1'b0;
        i_issue_en = 1'b1; i_issue_sel = 5'd0; i_chk_sel_1 = 5'd0;
        @(negedge clk);
        chk("x0_ld_count1", 32'(o_ld_count), 32'd1);
        next_cycle;
        i_issue_en = 1'b0;
        @(negedge clk);
        chk("x0_ld_count0", 32'(o_ld_count), 32'd0);
        chk("x0_ld_en", 32'(o_write_en), 32'd0);
        chk("x0_ld_data", o_write_data, 32'h66);
        chk("x0_busy", 32'(o_busy_1), 32'd0);

        // Set/clear collision on register 9
        next_cycle;
        i_issue_en = 1'b1; i_issue_sel = 5'd9; i_chk_sel_2 = 5'd9;
        next_cycle;
        i_issue_en = 1'b0;
        i_ld_valid = 1'b1; i_ld_sel = 5'd9; i_ld_data = 32'h99;
        push_exp(5'd9, 32'h99);
        next_cycle;
        i_ld_valid = 1'b0;
        next_cycle;
        i_issue_en = 1'b1; i_issue_sel = 5'd9;
        @(negedge clk);
        chk("col_commit_en", 32'(o_write_en), 32'd1);
        chk("col_busy_commit", 32'(o_busy_2), 32'd1);
        next_cycle;
        i_issue_en = 1'b0;
        @(negedge clk);
        chk("col_set_wins", 32'(o_busy_2), 32'd1);
        next_cycle;
        i_ld_valid = 1'b1; i_ld_sel = 5'd9; i_ld_data = 32'h9A;
        push_exp(5'd9, 32'h9A);
        next_cycle;
        i_ld_valid = 1'b0;
        next_cycle;
        @(negedge clk);
        chk("col_busy_second", 32'(o_busy_2), 32'd1);
        next_cycle;
        @(negedge clk);
        chk("col_busy_cleared", 32'(o_busy_2), 32'd0);

        // Reset in the middle of activity
        next_cycle;
        i_issue_en = 1'b1; i_issue_sel = 5'd12;
        next_cycle;
        i_issue_sel = 5'd13;
        next_cycle;
        i_issue_en = 1'b0;
        i_chk_sel_1 = 5'd12; i_chk_sel_2 = 5'd13;
        i_alu_valid = 1'b1; i_alu_sel = 5'd3; i_alu_data = 32'h33;
        i_ld_valid  = 1'b1; i_ld_sel  = 5'd12; i_ld_data = 32'hC12;
        push_exp(5'd3, 32'h33);
        next_cycle;
        i_alu_sel = 5'd4; i_alu_data = 32'h44;
        i_ld_sel  = 5'd13; i_ld_data = 32'hD13;
        push_exp(5'd4, 32'h44);
        @(negedge clk);
        chk("rmid_count1", 32'(o_ld_count), 32'd1);
        next_cycle;
        i_alu_valid = 1'b0; i_ld_valid = 1'b0;
        i_rst = 1'b1;
        @(negedge clk);
        chk("rmid_pre_en", 32'(o_write_en), 32'd1);
        chk("rmid_pre_count", 32'(o_ld_count), 32'd2);
        chk("rmid_pre_busy12", 32'(o_busy_1), 32'd1);
        chk("rmid_pre_busy13", 32'(o_busy_2), 32'd1);
        next_cycle;
        i_rst = 1'b0;
        @(negedge clk);
        chk("rmid_en", 32'(o_write_en), 32'd0);
        chk("rmid_count", 32'(o_ld_count), 32'd0);
        chk("rmid_busy12", 32'(o_busy_1), 32'd0);
        chk("rmid_busy13", 32'(o_busy_2), 32'd0);
        chk("rmid_ld_ready", 32'(o_ld_ready), 32'd1);
        chk("rmid_sel", 32'(o_sel_write), 32'd0);
        next_cycle;
        @(negedge clk);
        chk("rmid_after_en", 32'(o_write_en), 32'd0);
        chk("rmid_after_count", 32'(o_ld_count), 32'd0);

        repeat (3) next_cycle;
        @(negedge clk);
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regs_writeback.md
Name: regs_writeback

Overview:
- Writeback initiator for the register file: merges ALU results and load results onto the register file's single write port (write enable, write select, write data).
- Buffers load returns in a small FIFO.
- Keeps a pending-load scoreboard so decode can stall on registers whose load has not yet committed.
- Sits between execute/memory and the register file, one write per cycle.

Parameters:
LD_DEPTH, 2, load-return FIFO entries (power of two, >=2)
NUM_REGS, params::NUM_REGS, scoreboard size; register selects use reg_sel_t, data uses data_t

Ports:
i_clk  in  1  clock; all state updates on posedge
i_rst  in  1  synchronous reset, active-high
i_alu_valid  in  1  ALU result offered
o_alu_ready  out  1  ALU result accepted this cycle when high with valid
i_alu_sel  in  reg_sel_t  ALU destination register
i_alu_data  in  data_t  ALU result
i_ld_valid  in  1  load return offered
o_ld_ready  out  1  load return accepted this cycle when high with valid
i_ld_sel  in  reg_sel_t  load destination register
i_ld_data  in  data_t  load data
i_issue_en  in  1  load issued this cycle; marks i_issue_sel pending
i_issue_sel  in  reg_sel_t  destination of issued load
i_chk_sel_1  in  reg_sel_t  decode source 1 select to check
i_chk_sel_2  in  reg_sel_t  decode source 2 select to check
o_busy_1  out  1  pending[i_chk_sel_1], combinational
o_busy_2  out  1  pending[i_chk_sel_2], combinational
o_write_en  out  1  register file write enable, registered
o_sel_write  out  reg_sel_t  register file write select, registered
o_write_data  out  data_t  register file write data, registered
o_ld_count  out  $clog2(LD_DEPTH)+1  FIFO occupancy

Behaviour:
- Interface: one clock i_clk; reset i_rst is synchronous, active-high.
- Reset:
  - FIFO empty (o_ld_count=0), all pending bits 0.
  - o_write_en=0, o_sel_write=0, o_write_data=0.
  - Reset mid-operation discards FIFO contents and any in-flight output. No write is issued on the cycle after reset.
- Handshakes:
  - o_ld_ready = (count != LD_DEPTH), derived from registered count. A pop in the same cycle does not raise ready.
  - o_alu_ready = (count != LD_DEPTH).
  - Transfer occurs when valid && ready. Offered data must be held while not accepted.
- Selection, evaluated each cycle on registered FIFO state:
  - FIFO full: pop FIFO head; ALU is stalled.
  - Otherwise, ALU valid: ALU wins.
  - Otherwise, FIFO non-empty: pop head.
  - Otherwise: no write.
- Loads accepted in cycle N are not eligible until N+1, so there is no same-cycle bypass.
- Output register loads the selected entry at the edge ending the selection cycle:
  - ALU accepted in cycle N: o_write_en visible in N+1.
  - Load accepted in N with empty FIFO and no ALU: visible in N+2.
- o_write_en = selected && sel != 0. A sel 0 entry is consumed (FIFO pop / ALU accept) but never written. o_sel_write/o_write_data update on every selection and hold when nothing is selected.
- FIFO push and pop in the same cycle: count unchanged. Pointers wrap modulo LD_DEPTH.
- Scoreboard:
  - Internal registered flag marks that the output write came from a load.
  - A pending bit is cleared at the edge where the register file commits that write, i.e. the edge ending the cycle with o_write_en=1 and the load flag set. o_busy therefore falls exactly when the register file holds the new value.
  - Set on i_issue_en with i_issue_sel != 0. Set and clear of the same register in the same cycle: set wins.
  - ALU writes never clear pending bits.
  - o_busy for select 0 is always 0.
- Ordering: load returns write in arrival order. WAW ordering between ALU and loads to the same register is the issuer's responsibility (it stalls on o_busy).

Test Plan:
- ALU only: alu_valid, sel=5, data=0x1234 in cycle 1 -> cycle 2 o_write_en=1, o_sel_write=5, o_write_data=0x1234; cycle 3 o_write_en=0 with outputs held.
- Load with scoreboard: issue_sel=7 cycle 1 -> o_busy_1=1 for chk_sel_1=7 from cycle 2. ld_valid sel=7, data=0xCAFE cycle 4 -> write visible cycle 6. o_busy_1=1 through cycle 6, 0 in cycle 7.
- Contention: ALU valid every cycle (sel 1..6), two loads accepted back-to-back -> FIFO reaches 2, o_alu_ready=0 for one cycle, load heads written in arrival order, ALU resumes, no result lost or duplicated.
- x0: ALU sel=0 and load sel=0 accepted -> o_write_en stays 0. Load sel=0 frees its FIFO slot. Issue with sel=0 leaves o_busy 0.
- Set/clear collision: load to reg 9 commits on the same edge a new issue_sel=9 arrives -> pending[9] remains 1.
- Reset mid-op: FIFO holding 2 loads, pending bits set, o_write_en=1, assert i_rst one cycle -> next cycle o_write_en=0, o_ld_count=0, all o_busy=0, o_ld_ready=1.
